watch_key_ctrl: RTL and testbench



---
 rtl/watch_pkg.sv | 38 +++
 rtl/watch_tick_div.sv | 25 ++
 rtl/watch_key_ctrl.sv | 141 ++++++++++++++
 tb/tb_watch_key_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch keypad / time-set logic.
package watch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN_C1,
    SCAN_C2,
    HOLD
  } state_e;

  localparam int unsigned HOUR_H = 5;
  localparam int unsigned HOUR_L = 4;
  localparam int unsigned MIN_H  = 3;
  localparam int unsigned MIN_L  = 2;
  localparam int unsigned SEC_H  = 1;
  localparam int unsigned SEC_L  = 0;

  localparam logic [2:0] ROWS_IDLE = 3'b111;

  localparam logic [1:0] COL_NONE = 2'b00;
  localparam logic [1:0] COL1     = 2'b01;
  localparam logic [1:0] COL2     = 2'b10;

  // Rows are {row2,row3,row4} active-low; row2 has priority.
  function automatic logic [1:0] row_index(input logic [2:0] rows);
    logic [1:0] idx;
    if (!rows[2])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else               idx = 2'd2;
    return idx;
  endfunction

  // Key code k selects digit bit HOUR_H-k.
  function automatic logic [5:0] code_to_digit(input logic [2:0] code);
    return 6'b100000 >> code;
  endfunction

endpackage

// File: rtl/watch_tick_div.sv
// Free-running scan tick divider: one-cycle tick every SCAN_DIV clocks.
module watch_tick_div #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/watch_key_ctrl.sv
// 2x3 keypad scanner with debounce; emits one increment command per key press.
module watch_key_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 16,
  parameter int unsigned DEB_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       set_mode,
  input  logic [2:0] key_row,
  output logic [1:0] key_col,
  output logic [5:0] inc_pulse,
  output logic       key_valid,
  output logic [2:0] key_code,
  output logic       busy
);

  localparam int unsigned DW = $clog2(DEB_SAMPLES + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_SAMPLES);

  state_e        state_q, state_d;
  logic [DW-1:0] deb_q, deb_d, rel_q, rel_d;
  logic [1:0]    key_col_q, key_col_d;
  logic [5:0]    inc_pulse_q, inc_pulse_d;
  logic          key_valid_q, key_valid_d;
  logic [2:0]    key_code_q, key_code_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic          row_low;
  logic          hit;
  logic          hit_col;
  logic [DW-1:0] deb_inc, rel_inc;

  watch_tick_div #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  assign row_low = (key_row != ROWS_IDLE);
  assign deb_inc = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;
  assign rel_inc = (rel_q == DEB_MAX) ? rel_q : rel_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    rel_d       = rel_q;
    key_col_d   = key_col_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    inc_pulse_d = '0;
    hit         = 1'b0;
    hit_col     = 1'b0;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!row_low) begin
            deb_d = '0;
          end else if (deb_inc == DEB_MAX) begin
            deb_d     = '0;
            state_d   = SCAN_C1;
            key_col_d = COL1;
          end else begin
            deb_d = deb_inc;
          end
        end
        SCAN_C1: begin
          if (row_low) begin
            hit = 1'b1;
          end else begin
            state_d   = SCAN_C2;
            key_col_d = COL2;
          end
        end
        SCAN_C2: begin
          if (row_low) begin
            hit     = 1'b1;
            hit_col = 1'b1;
          end else begin
            state_d   = IDLE;
            key_col_d = COL_NONE;
          end
        end
        HOLD: begin
          if (row_low) begin
            rel_d = '0;
          end else if (rel_inc == DEB_MAX) begin
            rel_d     = '0;
            state_d   = IDLE;
            key_col_d = COL_NONE;
          end else begin
            rel_d = rel_inc;
          end
        end
      endcase
    end

    // The hit column stays driven through HOLD so release is seen on that column.
    if (hit) begin
      state_d     = HOLD;
      rel_d       = '0;
      key_code_d  = {row_index(key_row), hit_col};
      key_valid_d = 1'b1;
      inc_pulse_d = set_mode ? code_to_digit({row_index(key_row), hit_col}) : '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      deb_q       <= '0;
      rel_q       <= '0;
      key_col_q   <= COL_NONE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      inc_pulse_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      rel_q       <= rel_d;
      key_col_q   <= key_col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      inc_pulse_q <= inc_pulse_d;
      busy_q      <= busy_d;
    end
  end

  assign key_col   = key_col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign inc_pulse = inc_pulse_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_watch_key_ctrl.sv
// Bench for watch_key_ctrl: directed key table, random presses against a key-priority model, glitch and reset sequences.
module tb_watch_key_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       set_mode = 1'b0;
  logic [2:0] key_row;
  logic [1:0] key_col;
  logic [5:0] inc_pulse;
  logic       key_valid;
  logic [2:0] key_code;
  logic       busy;

  // Pressed keys, bit k = 2*row_idx + col_idx.
  logic [5:0] keys = '0;

  int tests = 0;
  int fails = 0;

  int valid_cnt = 0, pulse_cnt = 0, bad_pulse = 0;
  int busy_cnt = 0, c1_cnt = 0, c2_cnt = 0;
  logic [2:0] last_code = '0;
  logic [5:0] last_pulse = '0;

  always #5 clk = ~clk;

  // Keypad matrix: a row goes low when a pressed key sits on a driven (low) column.
  assign key_row[2] = ~((keys[0] & ~key_col[1]) | (keys[1] & ~key_col[0]));
  assign key_row[1] = ~((keys[2] & ~key_col[1]) | (keys[3] & ~key_col[0]));
  assign key_row[0] = ~((keys[4] & ~key_col[1]) | (keys[5] & ~key_col[0]));

  watch_key_ctrl #(.SCAN_DIV(4), .DEB_SAMPLES(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .set_mode  (set_mode),
    .key_row   (key_row),
    .key_col   (key_col),
    .inc_pulse (inc_pulse),
    .key_valid (key_valid),
    .key_code  (key_code),
    .busy      (busy)
  );

  always begin
    @(posedge clk);
    #2;
    if (key_valid) begin
      valid_cnt++;
      last_code  = key_code;
      last_pulse = inc_pulse;
    end
    if (inc_pulse != 6'b0) begin
      pulse_cnt++;
      if (!key_valid) bad_pulse++;
    end
    if (busy) busy_cnt++;
    if (key_col == 2'b01) c1_cnt++;
    if (key_col == 2'b10) c2_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Column 1 is scanned first; within a column the lowest row index wins.
  function automatic int model_code(input logic [5:0] m);
    int res = -1;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 3; r++)
        if (res < 0 && m[2*r+c]) res = 2*r + c;
    return res;
  endfunction

  task automatic run_press(input logic [5:0] m, input logic sm, input int ecode,
                           input logic [5:0] epulse);
    int v0, p0, n;
    logic [1:0] ecol;
    v0 = valid_cnt;
    p0 = pulse_cnt;
    ecol = (ecode % 2 == 1) ? 2'b10 : 2'b01;
    keys = m;
    set_mode = sm;
    n = 0;
    while (valid_cnt == v0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", 32'(valid_cnt != v0), 1);
    repeat (10) @(negedge clk);
    set_mode = ~sm;
    repeat (140) @(negedge clk);
    chk("valid_once", valid_cnt - v0, 1);
    chk("pulse_count", pulse_cnt - p0, sm ? 1 : 0);
    chk("key_code_at_valid", 32'(last_code), ecode);
    chk("inc_pulse_at_valid", 32'(last_pulse), 32'(epulse));
    chk("key_col_hold", 32'(key_col), 32'(ecol));
    chk("busy_hold", 32'(busy), 1);
    chk("key_code_held", 32'(key_code), ecode);
    keys = '0;
    repeat (30) @(negedge clk);
    chk("busy_after_release", 32'(busy), 0);
    chk("key_col_after_release", 32'(key_col), 0);
    chk("no_repeat", valid_cnt - v0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_key_col"}, 32'(key_col), 0);
    chk({tag, "_inc_pulse"}, 32'(inc_pulse), 0);
    chk({tag, "_key_valid"}, 32'(key_valid), 0);
    chk({tag, "_key_code"}, 32'(key_code), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  typedef struct {
    logic [5:0] keys;
    logic       sm;
    int         code;
    logic [5:0] pulse;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, p0, b0, a1, a2, lat;
    logic [5:0] m;
    logic sm;
    int code;

    tbl[0] = '{6'b100000, 1'b1, 5, 6'b000001};
    tbl[1] = '{6'b010001, 1'b1, 0, 6'b100000};
    tbl[2] = '{6'b000100, 1'b0, 2, 6'b000000};
    tbl[3] = '{6'b010010, 1'b1, 4, 6'b000010};
    tbl[4] = '{6'b001010, 1'b1, 1, 6'b010000};
    tbl[5] = '{6'b001000, 1'b1, 3, 6'b000100};

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    resetn = 1'b1;
    b0 = busy_cnt;
    repeat (20) @(negedge clk);
    chk("idle_no_busy", busy_cnt - b0, 0);
    chk("idle_key_col", 32'(key_col), 0);

    for (int i = 0; i < 6; i++)
      run_press(tbl[i].keys, tbl[i].sm, tbl[i].code, tbl[i].pulse);

    for (int i = 0; i < 12; i++) begin
      m = 6'($urandom_range(1, 63));
      sm = 1'($urandom_range(0, 1));
      code = model_code(m);
      run_press(m, sm, code, sm ? 6'(6'b100000 >> code) : 6'b0);
    end

    // One debounce sample only: must not leave IDLE.
    b0 = busy_cnt;
    v0 = valid_cnt;
    keys = 6'b000001;
    repeat (4) @(negedge clk);
    keys = '0;
    repeat (20) @(negedge clk);
    chk("glitch1_busy", busy_cnt - b0, 0);
    chk("glitch1_valid", valid_cnt - v0, 0);

    // Two samples then release before the column-1 sample: scan both columns, give up.
    a1 = c1_cnt;
    a2 = c2_cnt;
    v0 = valid_cnt;
    keys = 6'b000001;
    repeat (8) @(negedge clk);
    keys = '0;
    repeat (30) @(negedge clk);
    chk("glitch2_scan_c1", 32'(c1_cnt != a1), 1);
    chk("glitch2_scan_c2", 32'(c2_cnt != a2), 1);
    chk("glitch2_valid", valid_cnt - v0, 0);
    chk("glitch2_idle", 32'(busy), 0);

    // Reset while holding a key.
    keys = 6'b000100;
    set_mode = 1'b1;
    v0 = valid_cnt;
    for (int n = 0; n < 100 && valid_cnt == v0; n++) @(negedge clk);
    chk("hold_valid_seen", 32'(valid_cnt != v0), 1);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    keys = '0;
    @(negedge clk);
    chk_reset_vals("rst_hold");
    resetn = 1'b1;
    v0 = valid_cnt;
    repeat (30) @(negedge clk);
    chk("rst_hold_quiet", valid_cnt - v0, 0);

    // Measure latency from a reset-aligned press, then reset one cycle before the pulse.
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    keys = 6'b000100;
    set_mode = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!key_valid && lat < 100);
    chk("aligned_latency", lat, 12);
    keys = '0;
    repeat (30) @(negedge clk);

    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    keys = 6'b000100;
    v0 = valid_cnt;
    p0 = pulse_cnt;
    repeat (lat - 1) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_prepulse");
    chk("rst_prepulse_no_pulse", pulse_cnt - p0, 0);
    chk("rst_prepulse_no_valid", valid_cnt - v0, 0);
    keys = '0;
    resetn = 1'b1;
    repeat (10) @(negedge clk);

    chk("pulse_without_valid", bad_pulse, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
